// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: op codes, flag bit positions, FSM states and op-class helpers for the serial ALU
package alu_serial_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic is_sub(input logic [2:0] op);
    return op == OP_SUB || op == OP_SBC || op == OP_CP;
  endfunction
  function automatic logic is_logic(input logic [2:0] op);
    return op[2] && op != OP_CP;
  endfunction
endpackage

// File: rtl/alu_nibble.sv
// alu_nibble: combinational 4-bit slice (a, b, cin, op -> result, cout); cout is borrow-out for sub/sbc/cp, 0 for logic ops
module alu_nibble
  import alu_serial_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       cout
);
  logic [4:0] sum, diff;
  assign sum = {1'b0, a} + {1'b0, b} + {4'b0, cin};
  assign diff = {1'b0, a} - {1'b0, b} - {4'b0, cin};
  assign result = op == OP_AND ? a & b : op == OP_XOR ? a ^ b : op == OP_OR ? a | b : is_sub(op) ? diff[3:0] : sum[3:0];
  assign cout = is_logic(op) ? 1'b0 : is_sub(op) ? diff[4] : sum[4];
endmodule

// File: rtl/alu_serial.sv
// alu_serial: nibble-serial ALU (start/alu_op/in_a/in_b/in_c -> ready/done/out/out_flags {Z,N,H,C}); ALU_SERIAL_BYPASS_EN makes and/xor/or single-cycle
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int HC_NIBBLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       out_flags
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0] op_r;
  logic [WIDTH-1:0] a_r, b_r, res_sh, a_rot, res_next, byp_res;
  logic [3:0] nib_res, flags_next, byp_flags;
  logic carry, h_r, h_next, nib_cout, accept, bypass, last;
  alu_nibble u_nib (
    .a(a_r[3:0]),
    .b(b_r[3:0]),
    .cin(carry),
    .op(op_r),
    .result(nib_res),
    .cout(nib_cout)
  );
  // a rotates so it is whole again on the last nibble (CP returns it); result fills from the top
  assign a_rot = WIDTH'({a_r[3:0], a_r} >> 4);
  assign res_next = WIDTH'({nib_res, res_sh} >> 4);
  assign ready = state == IDLE;
`ifdef ALU_SERIAL_BYPASS_EN
  assign bypass = ready && start && is_logic(alu_op);
  assign byp_res = alu_op == OP_AND ? in_a & in_b : alu_op == OP_XOR ? in_a ^ in_b : in_a | in_b;
`else
  assign bypass = 1'b0;
  assign byp_res = '0;
`endif
  assign accept = ready && start && !bypass;
  assign last = state == RUN && cnt == CW'(NIBBLES - 1);
  assign h_next = cnt == CW'(HC_NIBBLE) ? nib_cout : h_r;
  always_comb state_next = accept ? RUN : last ? IDLE : state;
  always_comb begin
    flags_next = '0;
    flags_next[FLAG_Z] = res_next == '0;
    flags_next[FLAG_N] = is_sub(op_r);
    flags_next[FLAG_H] = is_logic(op_r) ? op_r == OP_AND : h_next;
    flags_next[FLAG_C] = nib_cout;
    byp_flags = '0;
    byp_flags[FLAG_Z] = byp_res == '0;
    byp_flags[FLAG_H] = alu_op == OP_AND;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      op_r <= OP_ADD;
      a_r <= '0;
      b_r <= '0;
      res_sh <= '0;
      carry <= 1'b0;
      h_r <= 1'b0;
      out <= '0;
      out_flags <= '0;
      done <= 1'b0;
    end else begin
      done <= last || bypass;
      if (accept) begin
        op_r <= alu_op;
        a_r <= in_a;
        b_r <= in_b;
        cnt <= '0;
        h_r <= 1'b0;
        carry <= (alu_op == OP_ADC || alu_op == OP_SBC) && in_c;
      end else if (state == RUN) begin
        a_r <= a_rot;
        b_r <= b_r >> 4;
        res_sh <= res_next;
        carry <= nib_cout;
        h_r <= h_next;
        cnt <= last ? '0 : cnt + CW'(1);
      end
      if (last) begin
        out <= op_r == OP_CP ? a_rot : res_next;
        out_flags <= flags_next;
      end else if (bypass) begin
        out <= byp_res;
        out_flags <= byp_flags;
      end
    end
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: scoreboard bench for 8-bit (H from nibble 0) and 16-bit (H from nibble 2) serial ALUs
module tb_alu_serial;
  import alu_serial_pkg::*;
  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  fl;
  } exp_t;
`ifdef ALU_SERIAL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic start8 = 1'b0, c8 = 1'b0, ready8, done8;
  logic [2:0] op8 = '0;
  logic [7:0] a8 = '0, b8 = '0, out8;
  logic [3:0] fl8;
  logic start16 = 1'b0, c16 = 1'b0, ready16, done16;
  logic [2:0] op16 = '0;
  logic [15:0] a16 = '0, b16 = '0, out16;
  logic [3:0] fl16;
  int checks = 0, errors = 0;
  exp_t q8[$], q16[$];
  exp_t e8, e16;
  always #5 clk = ~clk;
  alu_serial #(.WIDTH(8), .HC_NIBBLE(0)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .alu_op(op8), .in_a(a8), .in_b(b8), .in_c(c8),
    .ready(ready8), .done(done8), .out(out8), .out_flags(fl8)
  );
  alu_serial #(.WIDTH(16), .HC_NIBBLE(2)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .alu_op(op16), .in_a(a16), .in_b(b16), .in_c(c16),
    .ready(ready16), .done(done16), .out(out16), .out_flags(fl16)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input int w, input int hc, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic c);
    int ia, ib, ci, m, hm, r;
    exp_t e;
    m = (1 << w) - 1;
    hm = (1 << (4 * (hc + 1))) - 1;
    ia = int'(a) & m;
    ib = int'(b) & m;
    ci = (op == OP_ADC || op == OP_SBC) ? int'(c) : 0;
    e.fl = '0;
    case (op)
      OP_ADD, OP_ADC: begin
        r = ia + ib + ci;
        e.fl[FLAG_C] = r > m;
        e.fl[FLAG_H] = (ia & hm) + (ib & hm) + ci > hm;
      end
      OP_SUB, OP_SBC, OP_CP: begin
        r = ia - ib - ci;
        e.fl[FLAG_C] = r < 0;
        e.fl[FLAG_H] = (ia & hm) - (ib & hm) - ci < 0;
        e.fl[FLAG_N] = 1'b1;
      end
      OP_AND: begin
        r = ia & ib;
        e.fl[FLAG_H] = 1'b1;
      end
      OP_XOR: r = ia ^ ib;
      default: r = ia | ib;
    endcase
    r = r & m;
    e.fl[FLAG_Z] = r == 0;
    e.res = op == OP_CP ? 16'(ia) : 16'(r);
    return e;
  endfunction
  function automatic int lat_of(input bit w, input logic [2:0] op);
    return (BYP && is_logic(op)) ? 0 : (w ? 4 : 2);
  endfunction
  task automatic issue(input bit w, input bit push, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic c);
    if (w) begin
      start16 = 1'b1; op16 = op; a16 = a; b16 = b; c16 = c;
      if (push) q16.push_back(model(16, 2, op, a, b, c));
    end else begin
      start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; c8 = c;
      if (push) q8.push_back(model(8, 0, op, {8'h0, a[7:0]}, {8'h0, b[7:0]}, c));
    end
    @(posedge clk);
    #1;
    start8 = 1'b0;
    start16 = 1'b0;
  endtask
  task automatic wait_done(input bit w, input int exp_lat);
    int lat;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (w ? done16 : done8) begin
        lat = i;
        break;
      end
    end
    check(w ? "dut16 latency" : "dut8 latency", lat, exp_lat);
  endtask
  task automatic run(input bit w, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic c);
    issue(w, 1'b1, op, a, b, c);
    wait_done(w, lat_of(w, op));
  endtask
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) check("dut8 done with empty scoreboard", q8.size(), 1);
      else begin
        e8 = q8.pop_front();
        check("dut8 out", {24'h0, out8}, {16'h0, e8.res});
        check("dut8 flags", fl8, e8.fl);
      end
    end
    if (!rst && done16) begin
      if (q16.size() == 0) check("dut16 done with empty scoreboard", q16.size(), 1);
      else begin
        e16 = q16.pop_front();
        check("dut16 out", out16, e16.res);
        check("dut16 flags", fl16, e16.fl);
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    check("reset ready8", ready8, 1);
    check("reset done8", done8, 0);
    check("reset out8", out8, 0);
    check("reset flags8", fl8, 0);
    check("reset ready16", ready16, 1);
    check("reset out16", out16, 0);
    rst = 1'b0;
    @(negedge clk);
    run(0, OP_ADD, 16'h3A, 16'hC6, 1'b0);
    check("add out", out8, 8'h00);
    check("add flags", fl8, 4'b1011);
    run(0, OP_SBC, 16'h10, 16'h01, 1'b1);
    check("sbc out", out8, 8'h0E);
    check("sbc flags", fl8, 4'b0110);
    run(0, OP_CP, 16'h42, 16'h42, 1'b0);
    check("cp out", out8, 8'h42);
    check("cp flags", fl8, 4'b1100);
    run(0, OP_CP, 16'h42, 16'h42, 1'b1);
    check("cp cin1 out", out8, 8'h42);
    check("cp cin1 flags", fl8, 4'b1100);
    run(0, OP_AND, 16'hF0, 16'h0F, 1'b0);
    check("and out", out8, 8'h00);
    check("and flags", fl8, 4'b1010);
    check("ready in done cycle", ready8, 1);
    run(0, OP_XOR, 16'h5A, 16'hFF, 1'b0);
    check("back-to-back xor out", out8, 8'hA5);
    check("back-to-back xor flags", fl8, 4'b0000);
    issue(0, 1'b1, OP_ADD, 16'h12, 16'h34, 1'b0);
    check("ready low in RUN", ready8, 0);
    start8 = 1'b1; op8 = OP_SUB; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    wait_done(0, 1);
    check("start in RUN ignored out", out8, 8'h46);
    check("start in RUN ignored flags", fl8, 4'b0000);
    repeat (4) @(negedge clk);
    run(0, OP_SUB, 16'h00, 16'h01, 1'b0);
    check("sub wrap out", out8, 8'hFF);
    check("sub wrap flags", fl8, 4'b0111);
    issue(0, 1'b0, OP_ADD, 16'h01, 16'h01, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort out", out8, 0);
    check("abort flags", fl8, 0);
    check("abort ready", ready8, 1);
    check("abort done", done8, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("no done after abort", done8, 0);
    run(1, OP_ADD, 16'h0FFF, 16'h0001, 1'b0);
    check("add16 out", out16, 16'h1000);
    check("add16 flags", fl16, 4'b0010);
    for (int i = 0; i < 24; i++)
      run(0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom));
    for (int i = 0; i < 12; i++)
      run(1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom));
    repeat (3) @(negedge clk);
    check("dut8 scoreboard drained", q8.size(), 0);
    check("dut16 scoreboard drained", q16.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
